branch_resolve_unit: RTL and testbench

- Resolves control-flow instructions at the E/M boundary and produces the update stream for the branch history table: `pc_m`, `cflow_valid` and `cflow_taken`.
- Compares the fetch-time prediction, carried down the pipeline, against the actual outcome. On a mismatch it raises a one-shot redirect and flush to fetch.
- Keeps saturating counters of resolved control-flow instructions and mispredictions for performance monitoring.

---
 rtl/branch_resolve_unit.sv | 106 ++++++++++
 tb/tb_branch_resolve_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Resolves control-flow instructions at E/M: BHT update strobe, mispredict redirect/flush, perf counters.
// Outputs are combinational from the M register, one cycle after E is sampled; stall_m holds M and suppresses repeat strobes.
module branch_resolve_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_e,
  input  logic [31:0]          pc_e,
  input  logic                 is_branch_e,
  input  logic                 is_jump_e,
  input  logic                 pred_taken_e,
  input  logic [31:0]          pred_target_e,
  input  logic                 actual_taken_e,
  input  logic [31:0]          actual_target_e,
  input  logic                 stall_m,
  input  logic                 flush_m,
  output logic [31:0]          pc_m,
  output logic                 cflow_valid,
  output logic                 cflow_taken,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 flush_fd,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic        valid_m;
  logic        is_branch_m;
  logic        is_jump_m;
  logic        pred_taken_m;
  logic        actual_taken_m;
  logic [31:0] pred_target_m;
  logic [31:0] actual_target_m;
  logic        done;

  logic        load_m;
  logic        is_cf_m;
  logic        taken_m;
  logic        mis_m;

  assign load_m  = !stall_m;
  assign is_cf_m = valid_m & (is_branch_m | is_jump_m);
  assign taken_m = is_jump_m | actual_taken_m;
  assign mis_m   = is_cf_m & ((pred_taken_m != taken_m) |
                              (pred_taken_m & taken_m & (pred_target_m != actual_target_m)));

  assign cflow_valid    = is_cf_m & !done;
  assign cflow_taken    = is_cf_m & taken_m;
  assign redirect_valid = cflow_valid & mis_m;
  assign flush_fd       = redirect_valid;
  assign redirect_pc    = !is_cf_m ? 32'd0 :
                          (taken_m ? actual_target_m : pc_m + 32'd4);

  // The E instruction younger than a mispredict is squashed on its way into M.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_m         <= 1'b0;
      pc_m            <= '0;
      is_branch_m     <= 1'b0;
      is_jump_m       <= 1'b0;
      pred_taken_m    <= 1'b0;
      pred_target_m   <= '0;
      actual_taken_m  <= 1'b0;
      actual_target_m <= '0;
    end else if (load_m) begin
      valid_m         <= valid_e & !flush_m & !redirect_valid;
      pc_m            <= pc_e;
      is_branch_m     <= is_branch_e;
      is_jump_m       <= is_jump_e;
      pred_taken_m    <= pred_taken_e;
      pred_target_m   <= pred_target_e;
      actual_taken_m  <= actual_taken_e;
      actual_target_m <= actual_target_e;
    end
  end

  // done remembers that the instruction held in M has already strobed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else if (load_m) begin
      done <= 1'b0;
    end else if (cflow_valid) begin
      done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (cflow_valid && (branch_count != CNT_MAX)) begin
        branch_count <= branch_count + CNT_ONE;
      end
      if (redirect_valid && (mispredict_count != CNT_MAX)) begin
        mispredict_count <= mispredict_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with an instruction-level reference model checked every cycle.
module tb_branch_resolve_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          valid_e;
  logic [31:0]   pc_e;
  logic          is_branch_e;
  logic          is_jump_e;
  logic          pred_taken_e;
  logic [31:0]   pred_target_e;
  logic          actual_taken_e;
  logic [31:0]   actual_target_e;
  logic          stall_m;
  logic          flush_m;
  logic [31:0]   pc_m;
  logic          cflow_valid;
  logic          cflow_taken;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          flush_fd;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  int checks = 0;
  int passes = 0;

  branch_resolve_unit #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_e(valid_e), .pc_e(pc_e),
    .is_branch_e(is_branch_e), .is_jump_e(is_jump_e), .pred_taken_e(pred_taken_e),
    .pred_target_e(pred_target_e), .actual_taken_e(actual_taken_e),
    .actual_target_e(actual_target_e), .stall_m(stall_m), .flush_m(flush_m),
    .pc_m(pc_m), .cflow_valid(cflow_valid), .cflow_taken(cflow_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_fd(flush_fd),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the instruction currently occupying M and whether it has been reported.
  logic        m_valid, m_cf, m_taken, m_pred, m_reported;
  logic [31:0] m_pc, m_ptgt, m_tgt;
  int          exp_bc, exp_mc;

  function automatic logic m_strobe();
    return m_valid && m_cf && !m_reported;
  endfunction

  function automatic logic m_mispredict();
    return m_strobe() && ((m_pred != m_taken) || (m_pred && m_taken && (m_ptgt != m_tgt)));
  endfunction

  function automatic logic [31:0] m_next_pc();
    if (!(m_valid && m_cf)) return 32'd0;
    return m_taken ? m_tgt : m_pc + 32'd4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_cf = 0; m_taken = 0; m_pred = 0; m_reported = 0;
      m_pc = 0; m_ptgt = 0; m_tgt = 0; exp_bc = 0; exp_mc = 0;
    end else begin
      logic s, mis;
      s   = m_strobe();
      mis = m_mispredict();
      if (s)   exp_bc = (exp_bc < CMAX) ? exp_bc + 1 : CMAX;
      if (mis) exp_mc = (exp_mc < CMAX) ? exp_mc + 1 : CMAX;
      if (!stall_m) begin
        m_valid    = valid_e && !flush_m && !mis;
        m_pc       = pc_e;
        m_cf       = is_branch_e || is_jump_e;
        m_taken    = is_jump_e || actual_taken_e;
        m_pred     = pred_taken_e;
        m_ptgt     = pred_target_e;
        m_tgt      = actual_target_e;
        m_reported = 0;
      end else if (s) begin
        m_reported = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_cflow_valid", {31'b0, cflow_valid}, {31'b0, m_strobe()});
      check("m_redirect_valid", {31'b0, redirect_valid}, {31'b0, m_mispredict()});
      check("m_flush_fd", {31'b0, flush_fd}, {31'b0, m_mispredict()});
      check("m_cflow_taken", {31'b0, cflow_taken}, {31'b0, m_valid && m_cf && m_taken});
      check("m_redirect_pc", redirect_pc, m_next_pc());
      check("m_branch_count", {28'b0, branch_count}, exp_bc);
      check("m_mispredict_count", {28'b0, mispredict_count}, exp_mc);
      if (m_valid) check("m_pc_m", pc_m, m_pc);
    end
  end

  task automatic set_e(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                       input logic pt, input logic [31:0] ptgt, input logic at, input logic [31:0] atgt);
    valid_e = v; pc_e = pc; is_branch_e = br; is_jump_e = jmp;
    pred_taken_e = pt; pred_target_e = ptgt; actual_taken_e = at; actual_target_e = atgt;
  endtask

  task automatic idle();
    set_e(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 0; stall_m = 0; flush_m = 0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    check("rst_cflow_valid", {31'b0, cflow_valid}, 32'd0);
    check("rst_pc_m", pc_m, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_counts", {24'b0, branch_count, mispredict_count}, 32'd0);
    rst_n = 1;

    // Correct prediction
    set_e(1, 32'h100, 1, 0, 1, 32'h200, 1, 32'h200);
    tick();
    check("ok_cflow_valid", {31'b0, cflow_valid}, 32'd1);
    check("ok_taken", {31'b0, cflow_taken}, 32'd1);
    check("ok_pc_m", pc_m, 32'h100);
    check("ok_redirect", {31'b0, redirect_valid}, 32'd0);
    idle();
    tick();
    check("ok_bc", {28'b0, branch_count}, 32'd1);
    check("ok_mc", {28'b0, mispredict_count}, 32'd0);

    // Direction mispredict; the following E instruction must be squashed
    set_e(1, 32'h100, 1, 0, 1, 32'h200, 0, 32'h200);
    tick();
    check("dir_redirect", {31'b0, redirect_valid}, 32'd1);
    check("dir_flush_fd", {31'b0, flush_fd}, 32'd1);
    check("dir_redirect_pc", redirect_pc, 32'h104);
    check("dir_taken", {31'b0, cflow_taken}, 32'd0);
    set_e(1, 32'h108, 1, 0, 0, 32'h0, 0, 32'h0);
    tick();
    check("dir_squash", {31'b0, cflow_valid}, 32'd0);
    check("dir_redirect_once", {31'b0, redirect_valid}, 32'd0);
    check("dir_mc", {28'b0, mispredict_count}, 32'd1);
    check("dir_bc", {28'b0, branch_count}, 32'd2);

    // JAL target mispredict (actual_taken ignored)
    set_e(1, 32'h180, 0, 1, 1, 32'h300, 0, 32'h340);
    tick();
    check("jal_redirect_pc", redirect_pc, 32'h340);
    check("jal_taken", {31'b0, cflow_taken}, 32'd1);
    check("jal_redirect", {31'b0, redirect_valid}, 32'd1);
    idle();
    tick();
    check("jal_pulse", {31'b0, redirect_valid}, 32'd0);
    check("jal_mc", {28'b0, mispredict_count}, 32'd2);

    // Mispredicted branch held in M for three stall cycles
    set_e(1, 32'h400, 1, 0, 0, 32'h0, 1, 32'h480);
    tick();
    check("stl_first_redirect", {31'b0, redirect_valid}, 32'd1);
    stall_m = 1;
    set_e(1, 32'h500, 1, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stl_no_strobe", {31'b0, cflow_valid}, 32'd0);
      check("stl_no_redirect", {31'b0, redirect_valid}, 32'd0);
      check("stl_pc_m", pc_m, 32'h400);
      check("stl_redirect_pc", redirect_pc, 32'h480);
      check("stl_bc", {28'b0, branch_count}, 32'd4);
      check("stl_mc", {28'b0, mispredict_count}, 32'd3);
    end
    stall_m = 0;
    tick();
    check("stl_next_strobe", {31'b0, cflow_valid}, 32'd1);
    check("stl_next_pc", pc_m, 32'h500);
    idle();
    tick();

    // flush_m kills the loading instruction; with stall it is ignored
    flush_m = 1;
    set_e(1, 32'h600, 1, 0, 0, 32'h0, 1, 32'h640);
    tick();
    check("fl_no_strobe", {31'b0, cflow_valid}, 32'd0);
    flush_m = 0;
    set_e(1, 32'h700, 1, 0, 1, 32'h780, 1, 32'h780);
    tick();
    check("fl_load", pc_m, 32'h700);
    flush_m = 1; stall_m = 1;
    set_e(1, 32'h800, 1, 0, 0, 32'h0, 0, 32'h0);
    tick();
    check("fl_hold_pc", pc_m, 32'h700);
    check("fl_hold_taken", {31'b0, cflow_taken}, 32'd1);
    flush_m = 0; stall_m = 0;
    idle();
    tick();
    check("fl_bc", {28'b0, branch_count}, 32'd6);

    // Asynchronous reset in the middle of a strobe
    set_e(1, 32'h900, 1, 0, 1, 32'h940, 0, 32'h940);
    tick();
    check("ar_pre", {31'b0, cflow_valid}, 32'd1);
    rst_n = 0;
    #1;
    check("ar_cflow_valid", {31'b0, cflow_valid}, 32'd0);
    check("ar_redirect", {31'b0, redirect_valid}, 32'd0);
    check("ar_pc_m", pc_m, 32'd0);
    check("ar_counts", {24'b0, branch_count, mispredict_count}, 32'd0);
    idle();
    tick();
    rst_n = 1;

    // 17 back-to-back correct branches saturate the 4-bit counter
    for (int i = 0; i < 17; i++) begin
      set_e(1, 32'h1000 + 32'(i * 4), 1, 0, 0, 32'h0, 0, 32'h0);
      tick();
    end
    idle();
    tick();
    check("sat_bc", {28'b0, branch_count}, 32'd15);

    // Fall-through redirect wraps at the top of the address space
    set_e(1, 32'hFFFF_FFFC, 1, 0, 1, 32'h10, 0, 32'h10);
    tick();
    check("wrap_redirect_pc", redirect_pc, 32'h0);
    check("wrap_redirect", {31'b0, redirect_valid}, 32'd1);
    idle();
    tick();
    check("wrap_mc", {28'b0, mispredict_count}, 32'd1);
    check("wrap_bc_held", {28'b0, branch_count}, 32'd15);

    repeat (2) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
